// File: rtl/parity_frame_pkg.sv
// parity_frame_pkg: shared state encoding, line levels and counter sizing for parity_frame_tx
//   frame_state_t : IDLE, START, DATA, PARITY, STOP
//   IDLE_LEVEL / START_LEVEL / STOP_LEVEL : serial line levels
//   cnt_width(n)  : max(1, $clog2(n)), width of a counter running 0..n-1
package parity_frame_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} frame_state_t;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/parity_gen_w.sv
// parity_gen_w: combinational even-parity generator (XOR-reduction of the word)
//   data_i   in  W : word to reduce
//   parity_o out 1 : ^data_i
module parity_gen_w #(
   parameter int W = 4
) (
   input  logic [W-1:0] data_i,
   output logic         parity_o
);
   assign parity_o = ^data_i;
endmodule

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: serial frame transmitter (start, data LSB first, parity, stop)
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    in  1      : in_data is valid
//   in_ready    out 1      : word accepted this cycle (IDLE and not in reset)
//   in_data     in  DATA_W : word to transmit
//   tx          out 1      : serial line, idles high
//   busy        out 1      : frame in progress
//   frame_done  out 1      : pulse during the last STOP cycle
//   Build option PARITY_FRAME_ODD_EN: transmit odd parity instead of even.
module parity_frame_tx import parity_frame_pkg::*; #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);
   localparam int DIV_W = cnt_width(CLKS_PER_BIT);
   localparam int BIT_W = cnt_width(DATA_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   frame_state_t      state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic              par_raw, par_bit, div_last;

   // Parity comes from a separate copy of the accepted word, since the shift register is consumed.
   parity_gen_w #(.W(DATA_W)) u_par (
      .data_i   (word_q),
      .parity_o (par_raw)
   );

`ifdef PARITY_FRAME_ODD_EN
   assign par_bit = ~par_raw;
`else
   assign par_bit = par_raw;
`endif

   assign div_last   = div_q == DIV_LAST;
   assign in_ready   = (state_q == IDLE) && !rst;
   assign busy       = state_q != IDLE;
   assign frame_done = (state_q == STOP) && div_last;
   assign tx = (state_q == START)  ? START_LEVEL :
               (state_q == DATA)   ? shreg_q[0]  :
               (state_q == PARITY) ? par_bit     :
               (state_q == STOP)   ? STOP_LEVEL  : IDLE_LEVEL;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      word_d  = word_q;
      // Every state exits on a divider wrap, so the divider is already 0 on each state entry.
      div_d   = (state_q == IDLE || div_last) ? '0 : div_q + 1'b1;
      bit_d   = (state_q == DATA && div_last) ? ((bit_q == BIT_LAST) ? '0 : bit_q + 1'b1) : bit_q;
      unique case (state_q)
         IDLE:    if (in_valid && in_ready) begin
                     state_d = START;
                     shreg_d = in_data;
                     word_d  = in_data;
                  end
         START:   state_d = div_last ? DATA : START;
         DATA:    if (div_last) begin
                     shreg_d = shreg_q >> 1;
                     state_d = (bit_q == BIT_LAST) ? PARITY : DATA;
                  end
         PARITY:  state_d = div_last ? STOP : PARITY;
         STOP:    state_d = div_last ? IDLE : STOP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         word_q  <= word_d;
      end
   end
endmodule
